// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the CPU blocks.
//   INSN_W        width of one fetched instruction (three halfwords)
//   HALF_W        width of one instruction-memory word
//   imem_state_t  boot-loader state encoding used by cpu_imem
package cpu_pkg;

  localparam int INSN_W = 48;
  localparam int HALF_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DAT_HI,
    DAT_LO
  } imem_state_t;

endpackage

// File: rtl/cpu_imem_if.sv
// cpu_imem_if: bundle between the instruction memory and its users.
//   hatch_address      byte address of the instruction to fetch (bit 0 ignored)
//   hatch_instruction  48-bit instruction at hatch_address, combinational
//   load_start         one-cycle pulse that begins or restarts a boot load
//   load_valid         load_data holds a stream byte
//   load_data          stream byte
//   load_ready         byte accepted in a cycle where load_valid && load_ready
// Modports: master = fetch stage / host bridge side, slave = cpu_imem.
interface cpu_imem_if
  import cpu_pkg::*;
;
  logic [31:0]       hatch_address;
  logic [INSN_W-1:0] hatch_instruction;
  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_ready;

  modport master (
    output hatch_address,
    input  hatch_instruction,
    output load_start,
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  hatch_address,
    output hatch_instruction,
    input  load_start,
    input  load_valid,
    input  load_data,
    output load_ready
  );

endinterface

// File: rtl/cpu_imem_ram.sv
// cpu_imem_ram: 2^ADDR_W x 16-bit storage.
//   clk            clock
//   we             write enable (synchronous)
//   waddr, wdata   write port
//   raddr0..2      three asynchronous read addresses
//   rdata0..2      corresponding read data
// Contents are deliberately never cleared, so an image survives reset.
module cpu_imem_ram
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [HALF_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [HALF_W-1:0] rdata0,
  output logic [HALF_W-1:0] rdata1,
  output logic [HALF_W-1:0] rdata2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [HALF_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-write value during the write cycle.
  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/cpu_imem.sv
// cpu_imem: instruction memory plus byte-stream boot loader.
//   clk, rst    clock and synchronous active-high reset
//   bus         cpu_imem_if.slave: fetch read port and load byte stream
//   load_busy   a load is in progress
//   core_hold   core reset request (rst or load in progress)
//   load_count  halfwords written by the current or last load
// Stream: N (16 bits, high byte first), then N big-endian halfwords written
// to consecutive addresses starting at 0, wrapping modulo the depth.
module cpu_imem
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        rst,
  cpu_imem_if.slave   bus,
  output logic        load_busy,
  output logic        core_hold,
  output logic [15:0] load_count
);

  imem_state_t       state;
  logic [ADDR_W-1:0] wptr;
  logic [15:0]       n_len;
  logic [7:0]        hold;
  logic              accept;
  logic              we;
  logic [ADDR_W-1:0] h0;
  logic [ADDR_W-1:0] h1;
  logic [ADDR_W-1:0] h2;
  logic [HALF_W-1:0] r0;
  logic [HALF_W-1:0] r1;
  logic [HALF_W-1:0] r2;
  logic              unused_addr_bits;

  // A restart pulse takes priority, so a byte arriving with it is refused.
  assign bus.load_ready = (state != IDLE) && !bus.load_start;
  assign accept         = bus.load_valid && bus.load_ready;
  assign we             = accept && (state == DAT_LO);
  assign load_busy      = (state != IDLE);
  assign core_hold      = rst | load_busy;

  // Halfword index; higher address bits alias and h+1/h+2 wrap naturally.
  assign h0 = bus.hatch_address[ADDR_W:1];
  assign h1 = h0 + ADDR_W'(1);
  assign h2 = h0 + ADDR_W'(2);
  assign unused_addr_bits = ^{bus.hatch_address[0], bus.hatch_address[31:ADDR_W+1]};

  assign bus.hatch_instruction = {r0, r1, r2};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      load_count <= '0;
      n_len      <= '0;
      hold       <= '0;
    end else if (bus.load_start) begin
      state      <= LEN_HI;
      wptr       <= '0;
      load_count <= '0;
    end else if (accept) begin
      case (state)
        LEN_HI: begin
          n_len[15:8] <= bus.load_data;
          state       <= LEN_LO;
        end
        LEN_LO: begin
          n_len[7:0] <= bus.load_data;
          state      <= ({n_len[15:8], bus.load_data} == 16'd0) ? IDLE : DAT_HI;
        end
        DAT_HI: begin
          hold  <= bus.load_data;
          state <= DAT_LO;
        end
        DAT_LO: begin
          wptr       <= wptr + ADDR_W'(1);
          load_count <= load_count + 16'd1;
          state      <= (load_count + 16'd1 == n_len) ? IDLE : DAT_HI;
        end
        default: state <= IDLE;
      endcase
    end
  end

  cpu_imem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk    (clk),
    .we     (we),
    .waddr  (wptr),
    .wdata  ({hold, bus.load_data}),
    .raddr0 (h0),
    .raddr1 (h1),
    .raddr2 (h2),
    .rdata0 (r0),
    .rdata1 (r1),
    .rdata2 (r2)
  );

endmodule

// File: tb/tb_cpu_imem.sv
// tb_cpu_imem: directed bench for cpu_imem. Instance a uses the default
// depth; instance b uses ADDR_W=4 to exercise index wrap and aliasing.
module tb_cpu_imem;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu_imem_if if_a ();
  cpu_imem_if if_b ();

  logic        busy_a, hold_a, busy_b, hold_b;
  logic [15:0] count_a, count_b;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] stream_q[$];
  int gap_max = 0;

  cpu_imem #(.ADDR_W(12)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave),
    .load_busy(busy_a), .core_hold(hold_a), .load_count(count_a)
  );

  cpu_imem #(.ADDR_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave),
    .load_busy(busy_b), .core_hold(hold_b), .load_count(count_b)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveByte(input bit sel, input logic [7:0] b);
    if (sel) begin if_b.load_valid = 1'b1; if_b.load_data = b; end
    else     begin if_a.load_valid = 1'b1; if_a.load_data = b; end
    tick();
    if (sel) if_b.load_valid = 1'b0;
    else     if_a.load_valid = 1'b0;
  endtask

  task automatic pulseStart(input bit sel);
    if (sel) if_b.load_start = 1'b1;
    else     if_a.load_start = 1'b1;
    tick();
    if (sel) if_b.load_start = 1'b0;
    else     if_a.load_start = 1'b0;
  endtask

  // Sends every queued byte, with up to gap_max idle cycles before each.
  task automatic applyStimulus(input bit sel);
    foreach (stream_q[i]) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
      driveByte(sel, stream_q[i]);
    end
    stream_q.delete();
  endtask

  task automatic checkInsn(input bit sel, input string tag, input logic [31:0] addr,
                           input logic [47:0] expected);
    if (sel) if_b.hatch_address = addr;
    else     if_a.hatch_address = addr;
    #1;
    checkOutput(tag, sel ? if_b.hatch_instruction : if_a.hatch_instruction, expected);
  endtask

  initial begin
    if_a.hatch_address = '0; if_a.load_start = 1'b0; if_a.load_valid = 1'b0; if_a.load_data = '0;
    if_b.hatch_address = '0; if_b.load_start = 1'b0; if_b.load_valid = 1'b0; if_b.load_data = '0;
    if_a.load_valid = 1'b1;
    tick(); tick();

    // Reset state
    checkOutput("rst_busy", busy_a, 1'b0);
    checkOutput("rst_ready", if_a.load_ready, 1'b0);
    checkOutput("rst_hold", hold_a, 1'b1);
    checkOutput("rst_count", count_a, 16'd0);
    if_a.load_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("rst_hold_drop", hold_a, 1'b0);

    // Prefill mem[0..3] = FFFF FFFF FFFF 0000
    pulseStart(0);
    stream_q = '{8'h00, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    applyStimulus(0);
    checkOutput("pre_count", count_a, 16'd4);
    checkInsn(0, "pre_addr0", 32'd0, 48'hFFFF_FFFF_FFFF);

    // Basic load
    pulseStart(0);
    checkOutput("basic_busy_start", busy_a, 1'b1);
    checkOutput("basic_hold_start", hold_a, 1'b1);
    stream_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    applyStimulus(0);
    checkOutput("basic_busy_before_last", busy_a, 1'b1);
    driveByte(0, 8'hBC);
    checkOutput("basic_busy_fall", busy_a, 1'b0);
    checkOutput("basic_hold_fall", hold_a, 1'b0);
    checkOutput("basic_count", count_a, 16'd3);
    checkInsn(0, "basic_addr0", 32'd0, 48'h1234_5678_9ABC);

    // Bytes in IDLE are refused and write nothing
    if_a.load_valid = 1'b1; if_a.load_data = 8'h00;
    #1;
    checkOutput("idle_ready", if_a.load_ready, 1'b0);
    tick();
    if_a.load_data = 8'h00; tick();
    if_a.load_data = 8'hAA; tick();
    if_a.load_data = 8'h55; tick();
    if_a.load_valid = 1'b0;
    checkOutput("idle_count", count_a, 16'd3);

    // Alignment
    checkInsn(0, "align_addr1", 32'd1, 48'h1234_5678_9ABC);
    checkInsn(0, "align_addr2", 32'd2, 48'h5678_9ABC_0000);

    // Zero-length header
    pulseStart(0);
    stream_q = '{8'h00, 8'h00};
    applyStimulus(0);
    checkOutput("zero_busy", busy_a, 1'b0);
    checkOutput("zero_count", count_a, 16'd0);
    checkInsn(0, "zero_addr0", 32'd0, 48'h1234_5678_9ABC);

    // Restart after one halfword, with a colliding byte on the restart cycle
    pulseStart(0);
    stream_q = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h44};
    applyStimulus(0);
    checkOutput("restart_count1", count_a, 16'd1);
    checkInsn(0, "restart_partial", 32'd0, 48'h1111_5678_9ABC);
    if_a.load_start = 1'b1; if_a.load_valid = 1'b1; if_a.load_data = 8'h00;
    #1;
    checkOutput("collide_ready", if_a.load_ready, 1'b0);
    tick();
    if_a.load_start = 1'b0; if_a.load_valid = 1'b0;
    checkOutput("collide_count", count_a, 16'd0);
    stream_q = '{8'h00, 8'h02, 8'h22, 8'h22, 8'h33, 8'h33};
    applyStimulus(0);
    checkOutput("restart_count2", count_a, 16'd2);
    checkOutput("restart_busy", busy_a, 1'b0);
    checkInsn(0, "restart_addr0", 32'd0, 48'h2222_3333_9ABC);

    // Reset mid-load keeps written halfwords
    pulseStart(0);
    stream_q = '{8'h00, 8'h03, 8'hAB, 8'hCD, 8'hEF};
    applyStimulus(0);
    checkOutput("midrst_count_pre", count_a, 16'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_hold_high", hold_a, 1'b1);
    tick();
    checkOutput("midrst_busy", busy_a, 1'b0);
    checkOutput("midrst_count", count_a, 16'd0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_hold_drop", hold_a, 1'b0);
    checkInsn(0, "midrst_addr0", 32'd0, 48'hABCD_3333_9ABC);

    // Backpressure plus read/write collision on mem[0]
    pulseStart(0);
    gap_max = 3;
    stream_q = '{8'h00, 8'h03, 8'hCA};
    applyStimulus(0);
    if_a.hatch_address = 32'd0;
    if_a.load_valid = 1'b1; if_a.load_data = 8'hFE;
    #1;
    checkOutput("collide_old", if_a.hatch_instruction, 48'hABCD_3333_9ABC);
    tick();
    if_a.load_valid = 1'b0;
    checkOutput("collide_new", if_a.hatch_instruction, 48'hCAFE_3333_9ABC);
    stream_q = '{8'hBE, 8'hEF, 8'hF0, 8'h0D};
    applyStimulus(0);
    gap_max = 0;
    checkOutput("gap_count", count_a, 16'd3);
    checkOutput("gap_busy", busy_a, 1'b0);
    checkInsn(0, "gap_image", 32'd0, 48'hCAFE_BEEF_F00D);

    // Wrap on a 16-deep instance: mem[i] = 1000+i, then a 17th overwrites mem[0]
    pulseStart(1);
    stream_q.push_back(8'h00);
    stream_q.push_back(8'h10);
    for (int i = 0; i < 16; i++) begin
      stream_q.push_back(8'h10);
      stream_q.push_back(8'(i));
    end
    applyStimulus(1);
    checkOutput("wrap_count16", count_b, 16'd16);
    checkInsn(1, "wrap_addr30", 32'd30, 48'h100F_1000_1001);
    checkInsn(1, "wrap_alias32", 32'd32, 48'h1000_1001_1002);
    pulseStart(1);
    stream_q.push_back(8'h00);
    stream_q.push_back(8'h11);
    for (int i = 0; i < 16; i++) begin
      stream_q.push_back(8'h10);
      stream_q.push_back(8'(i));
    end
    stream_q.push_back(8'hBE);
    stream_q.push_back(8'hEF);
    applyStimulus(1);
    checkOutput("wrap_count17", count_b, 16'd17);
    checkOutput("wrap_busy", busy_b, 1'b0);
    checkInsn(1, "wrap_overwrite", 32'd0, 48'hBEEF_1001_1002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
